// File: rtl/mod_exp_ctrl_if.sv
// Purpose : bundle of request, result and reducer signals for mod_exp_ctrl.
// Ports   : start/base/exp/N request, result/busy/done/err status,
//           out_mul/Continue/Data_Bram exchange with the combinational mod-N reducer.
// Modports: slave = the sequencer; master = requester plus reducer side.
interface mod_exp_ctrl_if #(
  parameter int WIDTH = 6
);
  // request side
  logic               start;
  logic [WIDTH-1:0]   base;
  logic [WIDTH-1:0]   exp;
  logic [WIDTH-1:0]   N;
  // status side
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;
  logic               err;
  // reducer exchange: out_mul/Continue go out, Data_Bram comes back in the same cycle
  logic [2*WIDTH-1:0] out_mul;
  logic               Continue;
  logic [WIDTH-1:0]   Data_Bram;

  modport slave (
    input  start, base, exp, N, Data_Bram,
    output out_mul, Continue, result, busy, done, err
  );

  // The master side both issues requests and supplies the reducer answer.
  modport master (
    output start, base, exp, N, Data_Bram,
    input  out_mul, Continue, result, busy, done, err
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Purpose : MSB-first square-and-multiply sequencer, result = base^exp mod N,
//           driving an external combinational mod-N reducer.
// Ports   : clk, rst_n (async active-low), bus (mod_exp_ctrl_if.slave).
// Timing  : done pulses 2 + 2*WIDTH + 2*popcount(exp) cycles after the start edge,
//           or 1 cycle after it when N == 0; start is ignored while busy.
module mod_exp_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  mod_exp_ctrl_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE_CAP = 3'd1,
    SQ_LD   = 3'd2,
    SQ_CAP  = 3'd3,
    MUL_LD  = 3'd4,
    MUL_CAP = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  // datapath registers
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   base_r;
  logic [WIDTH-1:0]   exp_r;
  logic [WIDTH-1:0]   N_r;
  logic [IW-1:0]      idx;
  logic [2*WIDTH-1:0] out_mul_r;

  // registered status outputs
  logic [WIDTH-1:0]   result_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;

  // combinational helpers
  logic               cont;
  logic [2*WIDTH-1:0] n_ext;
  logic [2*WIDTH-1:0] acc_ext;
  logic [2*WIDTH-1:0] base_ext;
  logic [WIDTH-1:0]   red_val;
  logic               cur_bit;
  logic               last_bit;

  assign n_ext    = {{WIDTH{1'b0}}, N_r};
  assign acc_ext  = {{WIDTH{1'b0}}, acc};
  assign base_ext = {{WIDTH{1'b0}}, base_r};

  // The reducer answers 0 for inputs already below N, so small values must
  // bypass it and be taken straight from out_mul.
  assign red_val  = (out_mul_r < n_ext) ? out_mul_r[WIDTH-1:0] : bus.Data_Bram;

  assign cur_bit  = exp_r[idx];
  assign last_bit = (idx == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.N == '0) ? DONE : PRE_CAP;
        end
      end
      PRE_CAP: state_nxt = SQ_LD;
      SQ_LD:   state_nxt = SQ_CAP;
      SQ_CAP: begin
        if (cur_bit) begin
          state_nxt = MUL_LD;
        end else if (last_bit) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SQ_LD;
        end
      end
      MUL_LD:  state_nxt = MUL_CAP;
      MUL_CAP: state_nxt = last_bit ? DONE : SQ_LD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: the reducer is enabled only while a capture state consumes it
  // ---------------------------------------------------------------------------
  always_comb begin
    cont = 1'b0;
    unique case (state)
      PRE_CAP, SQ_CAP, MUL_CAP: cont = 1'b1;
      default:                  cont = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      base_r    <= '0;
      exp_r     <= '0;
      N_r       <= '0;
      idx       <= '0;
      out_mul_r <= '0;
      result_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            base_r <= bus.base;
            exp_r  <= bus.exp;
            N_r    <= bus.N;
            busy_r <= 1'b1;
            err_r  <= (bus.N == '0);
            // base may already be >= N, so it goes through one reduction first
            if (bus.N != '0) begin
              out_mul_r <= {{WIDTH{1'b0}}, bus.base};
            end
          end
        end
        PRE_CAP: begin
          base_r <= red_val;
          // 1 mod N is 0 for N == 1; keeps acc < N_r from the outset
          acc    <= (N_r == WIDTH'(1)) ? '0 : WIDTH'(1);
          idx    <= IW'(WIDTH - 1);
        end
        SQ_LD: begin
          out_mul_r <= acc_ext * acc_ext;
        end
        SQ_CAP: begin
          acc <= red_val;
          // a set bit keeps idx for the multiply step, which then advances it
          if (!cur_bit && !last_bit) begin
            idx <= idx - 1'b1;
          end
        end
        MUL_LD: begin
          out_mul_r <= acc_ext * base_ext;
        end
        MUL_CAP: begin
          acc <= red_val;
          if (!last_bit) begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          result_r <= err_r ? '0 : acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_mul  = out_mul_r;
  assign bus.Continue = cont;
  assign bus.result   = result_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl; also acts as the combinational mod-N reducer.
module tb_mod_exp_ctrl;
  localparam int W = 6;

  logic clk;
  logic rst_n;
  logic [W-1:0]   n_red;
  logic [2*W-1:0] n12;
  logic [2*W-1:0] dbram;

  int n_chk;
  int n_pass;

  mod_exp_ctrl_if #(.WIDTH(W)) bus ();

  mod_exp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reducer model: x mod N, but 0 when x < N (mirrors the real reducer quirk).
  always_comb begin
    n12 = {{W{1'b0}}, n_red};
    if (n_red == '0 || bus.out_mul < n12) dbram = '0;
    else                                  dbram = bus.out_mul % n12;
  end
  assign bus.Data_Bram = dbram[W-1:0];

  // Stimulus only: issues one request, watches until done (bounded), reports observations.
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                        input bit pester, output int cycles, output int cont_cnt,
                        output bit busy_seen);
    @(negedge clk);
    bus.base  = b;
    bus.exp   = e;
    bus.N     = n;
    n_red     = n;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // later input changes must be ignored
    bus.base  = W'($urandom);
    bus.exp   = W'($urandom);
    bus.N     = W'($urandom);
    busy_seen = bus.busy;
    cycles    = 0;
    cont_cnt  = 0;
    while (!bus.done && cycles < 100) begin
      cont_cnt += int'(bus.Continue);
      @(posedge clk);
      #1;
      cycles++;
      if (pester) bus.start = (cycles >= 3 && cycles <= 10);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base = '0; bus.exp = '0; bus.N = '0; n_red = '0;
    #3;
    n_chk++; if (bus.out_mul !== '0) $display("FAIL reset_out_mul got %0d exp 0", bus.out_mul); else n_pass++;
    n_chk++; if (bus.Continue !== 1'b0) $display("FAIL reset_continue got %0d exp 0", bus.Continue); else n_pass++;
    n_chk++; if (bus.result !== '0) $display("FAIL reset_result got %0d exp 0", bus.result); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0d exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0d exp 0", bus.done); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL reset_err got %0d exp 0", bus.err); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, cc; bit bs;
    run_op(6'd3, 6'd5, 6'd7, 1'b0, cyc, cc, bs);
    n_chk++; if (cyc != 18) $display("FAIL basic_latency got %0d exp 18", cyc); else n_pass++;
    n_chk++; if (bus.result !== 6'd5) $display("FAIL basic_result got %0d exp 5", bus.result); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL basic_err got %0d exp 0", bus.err); else n_pass++;
    n_chk++; if (bs !== 1'b1) $display("FAIL basic_busy_start got %0d exp 1", bs); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_done got %0d exp 0", bus.busy); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %0d exp 0", bus.done); else n_pass++;
    n_chk++; if (bus.result !== 6'd5) $display("FAIL basic_result_hold got %0d exp 5", bus.result); else n_pass++;
  endtask

  task automatic test_base_ge_n();
    int cyc, cc; bit bs;
    run_op(6'd10, 6'd3, 6'd7, 1'b0, cyc, cc, bs);
    n_chk++; if (bus.result !== 6'd6) $display("FAIL base_ge_n_result got %0d exp 6", bus.result); else n_pass++;
    n_chk++; if (cyc != 18) $display("FAIL base_ge_n_latency got %0d exp 18", cyc); else n_pass++;
  endtask

  task automatic test_exp_zero_n_one();
    int cyc, cc; bit bs;
    run_op(6'd5, 6'd0, 6'd7, 1'b0, cyc, cc, bs);
    n_chk++; if (bus.result !== 6'd1) $display("FAIL exp_zero_result got %0d exp 1", bus.result); else n_pass++;
    n_chk++; if (cyc != 14) $display("FAIL exp_zero_latency got %0d exp 14", cyc); else n_pass++;
    run_op(6'd9, 6'd4, 6'd1, 1'b0, cyc, cc, bs);
    n_chk++; if (bus.result !== 6'd0) $display("FAIL n_one_result got %0d exp 0", bus.result); else n_pass++;
    n_chk++; if (cyc != 16) $display("FAIL n_one_latency got %0d exp 16", cyc); else n_pass++;
  endtask

  task automatic test_back_to_back_max();
    int cyc, cc; bit bs;
    run_op(6'd63, 6'd63, 6'd61, 1'b1, cyc, cc, bs);
    n_chk++; if (bus.result !== 6'd8) $display("FAIL max_result got %0d exp 8", bus.result); else n_pass++;
    n_chk++; if (cyc != 26) $display("FAIL max_latency got %0d exp 26", cyc); else n_pass++;
    n_chk++; if (cc != 13) $display("FAIL max_continue_count got %0d exp 13", cc); else n_pass++;
  endtask

  task automatic test_n_zero();
    int cyc, cc; bit bs;
    run_op(6'd9, 6'd3, 6'd0, 1'b0, cyc, cc, bs);
    n_chk++; if (cyc != 1) $display("FAIL nzero_latency got %0d exp 1", cyc); else n_pass++;
    n_chk++; if (bus.result !== 6'd0) $display("FAIL nzero_result got %0d exp 0", bus.result); else n_pass++;
    n_chk++; if (bus.err !== 1'b1) $display("FAIL nzero_err got %0d exp 1", bus.err); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_chk++; if (bus.err !== 1'b1) $display("FAIL nzero_err_hold got %0d exp 1", bus.err); else n_pass++;
    run_op(6'd3, 6'd5, 6'd7, 1'b0, cyc, cc, bs);
    n_chk++; if (bus.err !== 1'b0) $display("FAIL nzero_err_clear got %0d exp 0", bus.err); else n_pass++;
    n_chk++; if (bus.result !== 6'd5) $display("FAIL nzero_next_result got %0d exp 5", bus.result); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int cyc, cc, dcount; bit bs;
    @(negedge clk);
    bus.base = 6'd3; bus.exp = 6'd5; bus.N = 6'd7; n_red = 6'd7; bus.start = 1'b1;
    @(posedge clk); #1;   // PRE_CAP
    bus.start = 1'b0;
    @(posedge clk); #1;   // SQ_LD
    @(posedge clk); #1;   // SQ_CAP
    n_chk++; if (bus.Continue !== 1'b1) $display("FAIL midrst_in_sqcap got %0d exp 1", bus.Continue); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.Continue !== 1'b0) $display("FAIL midrst_continue got %0d exp 0", bus.Continue); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %0d exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.out_mul !== '0) $display("FAIL midrst_out_mul got %0d exp 0", bus.out_mul); else n_pass++;
    n_chk++; if (bus.result !== '0) $display("FAIL midrst_result got %0d exp 0", bus.result); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      dcount += int'(bus.done);
    end
    n_chk++; if (dcount != 0) $display("FAIL midrst_no_done got %0d exp 0", dcount); else n_pass++;
    run_op(6'd3, 6'd5, 6'd7, 1'b0, cyc, cc, bs);
    n_chk++; if (bus.result !== 6'd5) $display("FAIL midrst_rerun_result got %0d exp 5", bus.result); else n_pass++;
    n_chk++; if (cyc != 18) $display("FAIL midrst_rerun_latency got %0d exp 18", cyc); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_base_ge_n();
    test_exp_zero_n_one();
    test_back_to_back_max();
    test_n_zero();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
